// File: rtl/cpu_types_pkg.sv
// ----------------------------------------------------------------------------
// cpu_types_pkg
//   Shared CPU types. Holds the instruction-cache FSM state type, the frame
//   layout, and the default cache geometry.
//   No ports (package).
// ----------------------------------------------------------------------------
package cpu_types_pkg;

   localparam int unsigned WORD_W         = 32;
   localparam int unsigned ICACHE_SETS    = 16;
   localparam int unsigned ICACHE_INDEX_W = 4;

   typedef logic [WORD_W-1:0] word_t;

   typedef enum logic {
      IDLE  = 1'b0,
      FETCH = 1'b1
   } icache_state_t;

   // One cache frame at the default geometry (tag excludes index and byte offset).
   typedef struct packed {
      logic                               valid;
      logic [WORD_W-ICACHE_INDEX_W-3:0]   tag;
      word_t                              data;
   } icache_frame_t;

endpackage

// File: rtl/icache_mem_if.sv
// ----------------------------------------------------------------------------
// icache_mem_if
//   Instruction port between the icache and the memory controller.
//   iREN  : cache -> mem, read request
//   iaddr : cache -> mem, read address
//   iwait : mem -> cache, busy; iload valid when iREN=1 and iwait=0
//   iload : mem -> cache, read data
// ----------------------------------------------------------------------------
interface icache_mem_if #(
   parameter int unsigned WORD_W = 32
);
   logic              iREN;
   logic [WORD_W-1:0] iaddr;
   logic              iwait;
   logic [WORD_W-1:0] iload;

   modport cache (output iREN, output iaddr, input iwait, input iload);
   modport mem   (input iREN, input iaddr, output iwait, output iload);
endinterface

// File: rtl/icache_array.sv
// ----------------------------------------------------------------------------
// icache_array
//   Frame storage for the direct-mapped icache: valid bit, tag and data word
//   per set. Combinational read port, one synchronous write port, and a
//   synchronous clear-all of the valid bits. Tag and data are not reset.
//   clk_i     : clock
//   clr_i     : clear every valid bit (priority over write)
//   we_i      : write frame windex_i with valid=1, wtag_i, wdata_i
//   rindex_i  : read index; rvalid_o/rtag_o/rdata_o are the frame contents
// ----------------------------------------------------------------------------
module icache_array #(
   parameter int unsigned SETS    = 16,
   parameter int unsigned INDEX_W = 4,
   parameter int unsigned TAG_W   = 26,
   parameter int unsigned DATA_W  = 32
) (
   input  logic               clk_i,
   input  logic               clr_i,
   input  logic               we_i,
   input  logic [INDEX_W-1:0] windex_i,
   input  logic [TAG_W-1:0]   wtag_i,
   input  logic [DATA_W-1:0]  wdata_i,
   input  logic [INDEX_W-1:0] rindex_i,
   output logic               rvalid_o,
   output logic [TAG_W-1:0]   rtag_o,
   output logic [DATA_W-1:0]  rdata_o
);

   logic [SETS-1:0]   valid_q;
   logic [TAG_W-1:0]  tag_q  [SETS];
   logic [DATA_W-1:0] data_q [SETS];

   always_ff @(posedge clk_i) begin
      if (clr_i) begin
         valid_q <= '0;
      end else if (we_i) begin
         valid_q[windex_i] <= 1'b1;
      end
   end

   always_ff @(posedge clk_i) begin
      if (we_i) begin
         tag_q[windex_i]  <= wtag_i;
         data_q[windex_i] <= wdata_i;
      end
   end

   assign rvalid_o = valid_q[rindex_i];
   assign rtag_o   = tag_q[rindex_i];
   assign rdata_o  = data_q[rindex_i];

endmodule

// File: rtl/icache_direct.sv
// ----------------------------------------------------------------------------
// icache_direct
//   Direct-mapped, one-word-block instruction cache. Hits are served in the
//   same cycle; a miss latches the address, fetches one word from memory,
//   fills the frame and then serves the request from IDLE.
//   CLK, RST            : clock, synchronous active-high reset
//   flush               : invalidate all frames; aborts a fetch in progress
//   imemREN, imemaddr   : datapath instruction request
//   ihit, imemload      : instruction valid / word (0 when ihit=0)
//   iREN, iaddr         : memory read request / address (0 outside FETCH)
//   iwait, iload        : memory busy / read data
// ----------------------------------------------------------------------------
module icache_direct #(
   parameter int unsigned SETS   = 16,
   parameter int unsigned WORD_W = 32
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic              flush,
   input  logic              imemREN,
   input  logic [WORD_W-1:0] imemaddr,
   output logic              ihit,
   output logic [WORD_W-1:0] imemload,
   output logic              iREN,
   output logic [WORD_W-1:0] iaddr,
   input  logic              iwait,
   input  logic [WORD_W-1:0] iload
);

   import cpu_types_pkg::*;

   localparam int unsigned INDEX_W = $clog2(SETS);
   localparam int unsigned TAG_W   = WORD_W - INDEX_W - 2;

   icache_mem_if #(.WORD_W(WORD_W)) mem_if ();

   icache_state_t     state_q, state_d;
   logic [WORD_W-1:0] maddr_q, maddr_d;

   logic [INDEX_W-1:0] req_index;
   logic [TAG_W-1:0]   req_tag;
   logic               fr_valid;
   logic [TAG_W-1:0]   fr_tag;
   logic [WORD_W-1:0]  fr_data;
   logic               lookup_hit;
   logic               fill;

   assign req_index = imemaddr[INDEX_W+1:2];
   assign req_tag   = imemaddr[WORD_W-1:INDEX_W+2];

   assign mem_if.iwait = iwait;
   assign mem_if.iload = iload;

   // Flush and reset both win over a fill completing in the same cycle.
   assign fill = (state_q == FETCH) && !mem_if.iwait && !flush && !RST;

   icache_array #(
      .SETS    (SETS),
      .INDEX_W (INDEX_W),
      .TAG_W   (TAG_W),
      .DATA_W  (WORD_W)
   ) u_array (
      .clk_i    (CLK),
      .clr_i    (RST | flush),
      .we_i     (fill),
      .windex_i (maddr_q[INDEX_W+1:2]),
      .wtag_i   (maddr_q[WORD_W-1:INDEX_W+2]),
      .wdata_i  (mem_if.iload),
      .rindex_i (req_index),
      .rvalid_o (fr_valid),
      .rtag_o   (fr_tag),
      .rdata_o  (fr_data)
   );

   // Hits only in IDLE; a flush in the same cycle still sees pre-flush contents.
   assign lookup_hit = !RST && (state_q == IDLE) && imemREN && fr_valid &&
                       (fr_tag == req_tag);

   always_comb begin
      state_d = state_q;
      maddr_d = maddr_q;
      unique case (state_q)
         IDLE: begin
            if (imemREN && !lookup_hit) begin
               state_d = FETCH;
               maddr_d = imemaddr;
            end
         end
         FETCH: begin
            if (flush || !mem_if.iwait) begin
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state_q <= IDLE;
         maddr_q <= '0;
      end else begin
         state_q <= state_d;
         maddr_q <= maddr_d;
      end
   end

   assign mem_if.iREN  = (state_q == FETCH) && !RST;
   assign mem_if.iaddr = mem_if.iREN ? maddr_q : '0;

   assign iREN     = mem_if.iREN;
   assign iaddr    = mem_if.iaddr;
   assign ihit     = lookup_hit;
   assign imemload = lookup_hit ? fr_data : '0;

endmodule

// File: tb/tb_icache_direct.sv
// ----------------------------------------------------------------------------
// tb_icache_direct
//   Directed testbench for icache_direct. Inputs are driven 1 time unit after
//   the rising edge and outputs are sampled on the falling edge.
// ----------------------------------------------------------------------------
module tb_icache_direct;

   logic        CLK = 1'b0;
   logic        RST;
   logic        flush;
   logic        imemREN;
   logic [31:0] imemaddr;
   logic        ihit;
   logic [31:0] imemload;
   logic        iREN;
   logic [31:0] iaddr;
   logic        iwait;
   logic [31:0] iload;

   int unsigned n_checks = 0;
   int unsigned n_fail   = 0;

   always #5 CLK = ~CLK;

   icache_direct #(
      .SETS   (16),
      .WORD_W (32)
   ) dut (
      .CLK      (CLK),
      .RST      (RST),
      .flush    (flush),
      .imemREN  (imemREN),
      .imemaddr (imemaddr),
      .ihit     (ihit),
      .imemload (imemload),
      .iREN     (iREN),
      .iaddr    (iaddr),
      .iwait    (iwait),
      .iload    (iload)
   );

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge CLK);
      #1;
   endtask

   // Miss detect cycle, waits+1 FETCH cycles (last one returns d), then hit.
   task automatic miss_fill(input logic [31:0] a, input int unsigned waits, input logic [31:0] d);
      imemREN  = 1'b1;
      imemaddr = a;
      iwait    = 1'b1;
      @(negedge CLK);
      check("miss_ihit", {31'b0, ihit}, 32'd0);
      check("miss_iren", {31'b0, iREN}, 32'd0);
      next_cycle();
      for (int unsigned i = 0; i <= waits; i++) begin
         iwait = (i < waits);
         iload = (i < waits) ? ~d : d;
         @(negedge CLK);
         check("fetch_iren",  {31'b0, iREN}, 32'd1);
         check("fetch_iaddr", iaddr, a);
         check("fetch_ihit",  {31'b0, ihit}, 32'd0);
         next_cycle();
      end
      iwait = 1'b1;
      iload = '0;
      @(negedge CLK);
      check("fill_ihit", {31'b0, ihit}, 32'd1);
      check("fill_data", imemload, d);
      check("fill_iren", {31'b0, iREN}, 32'd0);
      next_cycle();
   endtask

   task automatic hit_chk(input logic [31:0] a, input logic [31:0] d);
      imemREN  = 1'b1;
      imemaddr = a;
      @(negedge CLK);
      check("hit_ihit",  {31'b0, ihit}, 32'd1);
      check("hit_data",  imemload, d);
      check("hit_iren",  {31'b0, iREN}, 32'd0);
      check("hit_iaddr", iaddr, 32'd0);
      next_cycle();
   endtask

   initial begin
      RST      = 1'b1;
      flush    = 1'b0;
      imemREN  = 1'b1;
      imemaddr = 32'h0000_0040;
      iwait    = 1'b1;
      iload    = '0;
      next_cycle();

      // Reset state: outputs forced low while RST is high.
      @(negedge CLK);
      check("rst_ihit",  {31'b0, ihit}, 32'd0);
      check("rst_load",  imemload, 32'd0);
      check("rst_iren",  {31'b0, iREN}, 32'd0);
      check("rst_iaddr", iaddr, 32'd0);
      next_cycle();
      RST = 1'b0;

      // Cold miss, warm hit.
      miss_fill(32'h0000_0040, 3, 32'h8C01_0004);
      hit_chk(32'h0000_0040, 32'h8C01_0004);

      // Conflict on index 0.
      miss_fill(32'h0000_0440, 1, 32'h2002_0005);
      hit_chk(32'h0000_0440, 32'h2002_0005);
      miss_fill(32'h0000_0040, 0, 32'h8C01_0004);

      // Address change during FETCH is ignored; new address looked up after.
      imemaddr = 32'h0000_0080;
      @(negedge CLK);
      check("chg_miss_ihit", {31'b0, ihit}, 32'd0);
      next_cycle();
      imemaddr = 32'h0000_0084;
      iwait    = 1'b1;
      @(negedge CLK);
      check("chg_iaddr0", iaddr, 32'h0000_0080);
      check("chg_ihit0",  {31'b0, ihit}, 32'd0);
      next_cycle();
      iwait = 1'b0;
      iload = 32'hAAAA_0080;
      @(negedge CLK);
      check("chg_iaddr1", iaddr, 32'h0000_0080);
      check("chg_iren1",  {31'b0, iREN}, 32'd1);
      next_cycle();
      miss_fill(32'h0000_0084, 0, 32'hBBBB_0084);
      hit_chk(32'h0000_0080, 32'hAAAA_0080);

      // Flush in IDLE: same-cycle hit sees old contents, next request misses.
      imemaddr = 32'h0000_0080;
      flush    = 1'b1;
      @(negedge CLK);
      check("flush_same_ihit", {31'b0, ihit}, 32'd1);
      check("flush_same_data", imemload, 32'hAAAA_0080);
      next_cycle();
      flush = 1'b0;
      iwait = 1'b1;
      @(negedge CLK);
      check("flush_miss_ihit", {31'b0, ihit}, 32'd0);
      check("flush_miss_iren", {31'b0, iREN}, 32'd0);
      next_cycle();
      // Flush in FETCH with data ready: fill dropped.
      flush = 1'b1;
      iwait = 1'b0;
      iload = 32'hDEAD_BEEF;
      @(negedge CLK);
      check("fflush_iren",  {31'b0, iREN}, 32'd1);
      check("fflush_iaddr", iaddr, 32'h0000_0080);
      next_cycle();
      flush = 1'b0;
      iwait = 1'b1;
      @(negedge CLK);
      check("fflush_next_iren", {31'b0, iREN}, 32'd0);
      check("fflush_next_ihit", {31'b0, ihit}, 32'd0);
      next_cycle();
      iwait = 1'b0;
      iload = 32'h1234_0080;
      @(negedge CLK);
      check("refetch_iren",  {31'b0, iREN}, 32'd1);
      check("refetch_iaddr", iaddr, 32'h0000_0080);
      next_cycle();
      iwait = 1'b1;
      @(negedge CLK);
      check("refetch_ihit", {31'b0, ihit}, 32'd1);
      check("refetch_data", imemload, 32'h1234_0080);
      next_cycle();
      miss_fill(32'h0000_0084, 0, 32'hBBBB_0084);
      hit_chk(32'h0000_0080, 32'h1234_0080);

      // Reset in the middle of a fetch.
      imemaddr = 32'h0000_0440;
      @(negedge CLK);
      check("rf_miss_ihit", {31'b0, ihit}, 32'd0);
      next_cycle();
      @(negedge CLK);
      check("rf_fetch_iren", {31'b0, iREN}, 32'd1);
      next_cycle();
      RST     = 1'b1;
      imemREN = 1'b0;
      iwait   = 1'b0;
      iload   = 32'hFFFF_FFFF;
      @(negedge CLK);
      check("rf_rst_iren",  {31'b0, iREN}, 32'd0);
      check("rf_rst_iaddr", iaddr, 32'd0);
      check("rf_rst_ihit",  {31'b0, ihit}, 32'd0);
      next_cycle();
      RST = 1'b0;
      for (int i = 0; i < 4; i++) begin
         @(negedge CLK);
         check("rf_idle_iren",  {31'b0, iREN}, 32'd0);
         check("rf_idle_iaddr", iaddr, 32'd0);
         check("rf_idle_ihit",  {31'b0, ihit}, 32'd0);
         next_cycle();
      end
      iwait = 1'b1;
      miss_fill(32'h0000_0080, 0, 32'h5555_0080);
      miss_fill(32'h0000_0084, 2, 32'h6666_0084);
      miss_fill(32'h0000_0440, 0, 32'h7777_0440);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
